// File: rtl/branch_resolve.sv
// branch_resolve
// Multi-cycle resolver for MIPS conditional branches. A request captured in
// IDLE walks through CMP (subtract and flag capture), RESOLVE (decision and
// target computation) and DONE (one-cycle completion with PC write strobe).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request strobe, sampled only in IDLE
//   op              0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6/7 reserved
//   rs_val, rt_val  operands (rt_val used only by BEQ/BNE)
//   pc_plus4        branch address + 4
//   imm16           signed word offset
//   flush           aborts a request sitting in CMP or RESOLVE
//   busy            state is not IDLE
//   done            one-cycle completion pulse
//   taken, next_pc  decision and resulting PC, held until the next done
//   pc_write        done & taken
//   zero_flag       (rs - sel_rt) == 0 from the last CMP
module branch_resolve #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [15:0]      imm16,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic [WIDTH-1:0] next_pc,
    output logic             pc_write,
    output logic             zero_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMP     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [WIDTH-1:0]  rs_reg;
    logic [WIDTH-1:0]  rt_reg;
    logic [WIDTH-1:0]  pc_reg;
    logic [15:0]       imm_reg;
    logic              zero_flag_reg;
    logic              sign_reg;
    logic              taken_reg;
    logic [WIDTH-1:0]  next_pc_reg;

    logic [WIDTH-1:0]  sel_rt;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  offset;
    logic [WIDTH-1:0]  target;
    logic              taken_next;

    // Byte offset = sign_extend(imm16) << 2, built bit by bit.
    assign offset[1:0] = 2'b00;
    generate
        for (genvar gi = 0; gi < WIDTH - 2; gi++) begin : g_offset
            if (gi < 16) begin : g_lo
                assign offset[gi+2] = imm_reg[gi];
            end else begin : g_hi
                assign offset[gi+2] = imm_reg[15];
            end
        end
    endgenerate

    // Only the two-operand compares use rt; the zero-compare branches test rs alone.
    assign sel_rt = (op_reg == OP_BEQ || op_reg == OP_BNE) ? rt_reg : '0;
    assign diff   = rs_reg - sel_rt;
    assign target = pc_reg + offset;

    always_comb begin
        taken_next = 1'b0;
        case (op_reg)
            OP_BEQ:  taken_next = zero_flag_reg;
            OP_BNE:  taken_next = !zero_flag_reg;
            OP_BLEZ: taken_next = zero_flag_reg | sign_reg;
            OP_BGTZ: taken_next = !zero_flag_reg & !sign_reg;
            OP_BLTZ: taken_next = sign_reg;
            OP_BGEZ: taken_next = !sign_reg;
            default: taken_next = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CMP;
            CMP:     state_next = flush ? IDLE : RESOLVE;
            RESOLVE: state_next = flush ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            pc_reg        <= '0;
            imm_reg       <= '0;
            zero_flag_reg <= 1'b0;
            sign_reg      <= 1'b0;
            taken_reg     <= 1'b0;
            next_pc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg  <= op;
                        rs_reg  <= rs_val;
                        rt_reg  <= rt_val;
                        pc_reg  <= pc_plus4;
                        imm_reg <= imm16;
                    end
                end
                CMP: begin
                    // Flags are captured even if flushed; only the decision is protected.
                    zero_flag_reg <= (diff == '0);
                    sign_reg      <= rs_reg[WIDTH-1];
                end
                RESOLVE: begin
                    if (!flush) begin
                        taken_reg   <= taken_next;
                        next_pc_reg <= taken_next ? target : pc_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign pc_write  = done & taken_reg;
    assign taken     = taken_reg;
    assign next_pc   = next_pc_reg;
    assign zero_flag = zero_flag_reg;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed testbench for branch_resolve. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val, pc_plus4;
    logic [15:0] imm16;
    logic        flush;
    logic        busy, done, taken, pc_write, zero_flag;
    logic [31:0] next_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4), .imm16(imm16),
        .flush(flush), .busy(busy), .done(done), .taken(taken),
        .next_pc(next_pc), .pc_write(pc_write), .zero_flag(zero_flag)
    );

    // Present a request for one cycle, then scramble the operands so any
    // reliance on them after the start cycle shows up. Returns in CMP.
    task automatic issue(input logic [2:0] o, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] pc,
                         input logic [15:0] imm);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = rs; rt_val = rt; pc_plus4 = pc; imm16 = imm;
        @(negedge clk);
        start = 1'b0;
        op = 3'd7; rs_val = 32'hDEADBEEF; rt_val = 32'h12345678;
        pc_plus4 = 32'hCAFEF00D; imm16 = 16'hA5A5;
    endtask

    // Counts falling edges (starting at 1 in CMP) until done, bounded.
    task automatic wait_done(output int lat, output bit seen);
        lat = 1; seen = 1'b0;
        repeat (8) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (taken !== 1'b0 || pc_write !== 1'b0 || zero_flag !== 1'b0)
            begin failures++; $display("FAIL reset_flags got=%b%b%b exp=000", taken, pc_write, zero_flag); end
        checks++; if (next_pc !== 32'h0) begin failures++; $display("FAIL reset_next_pc got=%h exp=00000000", next_pc); end
        rst = 1'b0;
        $display("reset: busy=%b done=%b next_pc=%h", busy, done, next_pc);
    endtask

    // Runs one branch and checks latency, decision, PC, strobe and zero flag.
    task automatic test_branch(input string name, input logic [2:0] o,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] pc, input logic [15:0] imm,
                               input logic exp_taken, input logic [31:0] exp_pc,
                               input logic exp_zero);
        int lat; bit seen;
        issue(o, rs, rt, pc, imm);
        wait_done(lat, seen);
        checks++; if (!seen || lat != 3) begin failures++; $display("FAIL %s_latency got=%0d seen=%0b exp=3", name, lat, seen); end
        checks++; if (taken !== exp_taken) begin failures++; $display("FAIL %s_taken got=%b exp=%b", name, taken, exp_taken); end
        checks++; if (next_pc !== exp_pc) begin failures++; $display("FAIL %s_next_pc got=%h exp=%h", name, next_pc, exp_pc); end
        checks++; if (pc_write !== exp_taken) begin failures++; $display("FAIL %s_pc_write got=%b exp=%b", name, pc_write, exp_taken); end
        checks++; if (zero_flag !== exp_zero) begin failures++; $display("FAIL %s_zero_flag got=%b exp=%b", name, zero_flag, exp_zero); end
        $display("%s: op=%0d rs=%h rt=%h lat=%0d taken=%b next_pc=%h", name, o, rs, rt, lat, taken, next_pc);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s_return_idle done=%b busy=%b exp=0,0", name, done, busy); end
    endtask

    task automatic test_beq_bne();
        test_branch("beq_eq", 3'd0, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b1, 32'h110, 1'b1);
        test_branch("bne_eq", 3'd1, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b0, 32'h100, 1'b1);
        test_branch("bne_ne", 3'd1, 32'd7, 32'd5, 32'h200, 16'h0010, 1'b1, 32'h240, 1'b0);
    endtask

    task automatic test_sign_wrap();
        test_branch("blez_neg", 3'd2, 32'h80000000, 32'd9, 32'h100, 16'hFFFF, 1'b1, 32'h000000FC, 1'b0);
        test_branch("bgtz_zero", 3'd3, 32'h0, 32'd9, 32'h100, 16'h0004, 1'b0, 32'h100, 1'b1);
        test_branch("bgtz_pos", 3'd3, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b1, 32'h110, 1'b0);
        test_branch("bgez_zero", 3'd5, 32'h0, 32'd3, 32'h100, 16'h0001, 1'b1, 32'h104, 1'b1);
        test_branch("bltz_neg", 3'd4, 32'hFFFFFFFF, 32'd0, 32'h100, 16'h0002, 1'b1, 32'h108, 1'b0);
        test_branch("wrap", 3'd5, 32'h0, 32'd0, 32'hFFFFFFF0, 16'h7FFF, 1'b1, 32'h0001FFEC, 1'b1);
        test_branch("reserved", 3'd6, 32'h0, 32'd0, 32'h300, 16'h0004, 1'b0, 32'h300, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int extra = 0;
        issue(3'd0, 32'd1, 32'd1, 32'h400, 16'h0001);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_cmp got=%b exp=1", busy); end
        start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL busy_resolve busy=%b done=%b exp=1,0", busy, done); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || next_pc !== 32'h404) begin failures++; $display("FAIL busy_done done=%b next_pc=%h exp=1,00000404", done, next_pc); end
        repeat (6) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++; if (extra != 0 || busy !== 1'b0) begin failures++; $display("FAIL busy_no_queue extra_done=%0d busy=%b exp=0,0", extra, busy); end
        $display("start_while_busy: extra_done=%0d", extra);
    endtask

    task automatic test_flush();
        int seen_done = 0;
        // Leaves taken=1, next_pc=0x110 as the held result.
        test_branch("pre_flush", 3'd0, 32'd5, 32'd5, 32'h100, 16'h0004, 1'b1, 32'h110, 1'b1);
        issue(3'd1, 32'd3, 32'd3, 32'h500, 16'h0008);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pc_write !== 1'b0)
            begin failures++; $display("FAIL flush_idle busy=%b done=%b pc_write=%b exp=0,0,0", busy, done, pc_write); end
        checks++; if (taken !== 1'b1 || next_pc !== 32'h110)
            begin failures++; $display("FAIL flush_hold taken=%b next_pc=%h exp=1,00000110", taken, next_pc); end
        repeat (4) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++; if (seen_done != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", seen_done); end
        $display("flush: held taken=%b next_pc=%h", taken, next_pc);
        test_branch("post_flush", 3'd0, 32'd9, 32'd9, 32'h600, 16'h0002, 1'b1, 32'h608, 1'b1);
    endtask

    task automatic test_reset_mid();
        int lat; bit seen;
        issue(3'd0, 32'd2, 32'd2, 32'h700, 16'h0003);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pc_write !== 1'b0)
            begin failures++; $display("FAIL rstmid_ctrl busy=%b done=%b pc_write=%b exp=0,0,0", busy, done, pc_write); end
        checks++; if (taken !== 1'b0 || next_pc !== 32'h0 || zero_flag !== 1'b0)
            begin failures++; $display("FAIL rstmid_data taken=%b next_pc=%h zero=%b exp=0,0,0", taken, next_pc, zero_flag); end
        // Start presented in the first cycle after reset.
        start = 1'b1; op = 3'd0; rs_val = 32'd4; rt_val = 32'd4; pc_plus4 = 32'h800; imm16 = 16'h0004;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_accept busy=%b exp=1", busy); end
        wait_done(lat, seen);
        checks++; if (!seen || lat != 3 || taken !== 1'b1 || next_pc !== 32'h810)
            begin failures++; $display("FAIL rstmid_result seen=%0b lat=%0d taken=%b next_pc=%h exp=1,3,1,00000810", seen, lat, taken, next_pc); end
        $display("reset_mid: restart lat=%0d next_pc=%h", lat, next_pc);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit seen;
        issue(3'd0, 32'd1, 32'd2, 32'h900, 16'h0004);
        wait_done(lat, seen);
        checks++; if (!seen || taken !== 1'b0 || next_pc !== 32'h900)
            begin failures++; $display("FAIL b2b_first seen=%0b taken=%b next_pc=%h exp=1,0,00000900", seen, taken, next_pc); end
        // Flush during DONE must not cancel the committed pulse.
        flush = 1'b1;
        issue(3'd1, 32'd1, 32'd2, 32'hA00, 16'hFFFE);
        flush = 1'b0;
        wait_done(lat, seen);
        checks++; if (!seen || lat != 3 || taken !== 1'b1 || next_pc !== 32'h9F8 || pc_write !== 1'b1)
            begin failures++; $display("FAIL b2b_second seen=%0b lat=%0d taken=%b next_pc=%h pc_write=%b exp=1,3,1,000009f8,1", seen, lat, taken, next_pc, pc_write); end
        $display("back_to_back: second next_pc=%h", next_pc);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        rs_val = '0; rt_val = '0; pc_plus4 = '0; imm16 = '0;
        test_reset();
        test_beq_bne();
        test_sign_wrap();
        test_start_while_busy();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
